// File: rtl/load_store_unit.sv
// load_store_unit: RV32I load/store front-end for a word-only data_mem.
// Sub-word stores run as a read-modify-write pair because data_mem has no
// byte enables. Loads are lane-selected and sign/zero extended.
// Optional completion counters are built when LSU_STATS_EN is defined;
// otherwise stat_* are tied to zero.
module load_store_unit #(
    parameter int unsigned MEM_ADDR_W = 10,
    parameter int unsigned XLEN       = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           req_addr,
    input  logic [XLEN-1:0]       req_wdata,
    output logic                  resp_valid,
    output logic [XLEN-1:0]       resp_rdata,
    output logic                  resp_err,
    output logic                  mem_wr_sel,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]       mem_wr_data,
    input  logic [XLEN-1:0]       mem_rd_data,
    output logic [31:0]           stat_loads,
    output logic [31:0]           stat_stores,
    output logic [31:0]           stat_errs
);

    localparam int unsigned DEPTH  = 2 ** MEM_ADDR_W;
    localparam logic [1:0]  SIZE_B = 2'b00;
    localparam logic [1:0]  SIZE_H = 2'b01;
    localparam logic [1:0]  SIZE_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } state_e;

    // Request attributes kept for the whole transaction
    typedef struct packed {
        logic       we;
        logic [1:0] size;
        logic       unsgn;
        logic [1:0] lane;
    } req_t;

    state_e                state_q, state_d;
    req_t                  req_q, req_d;
    logic [MEM_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic                  acc_err;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [XLEN-1:0]       ld_ext;
    logic [XLEN-1:0]       st_merge;

    // Classify the incoming request as misaligned, illegal or out of range
    always_comb begin
        acc_err = 1'b0;
        case (req_size)
            SIZE_H:  acc_err = req_addr[0];
            SIZE_W:  acc_err = |req_addr[1:0];
            SIZE_B:  acc_err = 1'b0;
            default: acc_err = 1'b1;
        endcase
        if (req_addr[31:2] >= 30'(DEPTH)) begin
            acc_err = 1'b1;
        end
    end

    // Load lane select/extend and sub-word store merge
    always_comb begin
        ld_byte  = mem_rd_data[{req_q.lane, 3'b000} +: 8];
        ld_half  = mem_rd_data[{req_q.lane[1], 4'b0000} +: 16];
        case (req_q.size)
            SIZE_B:  ld_ext = {{(XLEN-8){ld_byte[7] & ~req_q.unsgn}}, ld_byte};
            SIZE_H:  ld_ext = {{(XLEN-16){ld_half[15] & ~req_q.unsgn}}, ld_half};
            default: ld_ext = mem_rd_data;
        endcase
        st_merge = mem_rd_data;
        if (req_q.size == SIZE_B) begin
            st_merge[{req_q.lane, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            st_merge[{req_q.lane[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    // Datapath register next-values
    always_comb begin
        req_d   = req_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    req_d.we    = req_we;
                    req_d.size  = req_size;
                    req_d.unsgn = req_unsigned;
                    req_d.lane  = req_addr[1:0];
                    err_d       = acc_err;
                    rdata_d     = '0;
                    if (!acc_err) begin
                        addr_d = req_addr[MEM_ADDR_W+1:2];
                        if (req_we) begin
                            wdata_d = req_wdata;
                        end
                    end
                end
            end
            LOAD:     rdata_d = ld_ext;
            RMW_READ: wdata_d = st_merge;
            default:  ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            req_q   <= req_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: errors skip memory, sub-word stores read first
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (acc_err) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (req_size == SIZE_W) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD:     state_d = RESP;
            RMW_READ: state_d = WRITE;
            WRITE:    state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // FSM outputs; the write strobe is gated by reset so an abort drops it
    always_comb begin
        req_ready   = (state_q == IDLE);
        resp_valid  = (state_q == RESP);
        mem_wr_sel  = (state_q == WRITE) && rst_n;
        mem_addr    = addr_q;
        mem_wr_data = wdata_q;
        resp_rdata  = rdata_q;
        resp_err    = err_q;
    end

`ifdef LSU_STATS_EN
    logic [31:0] loads_q, loads_d;
    logic [31:0] stores_q, stores_d;
    logic [31:0] errs_q, errs_d;

    // Count each completion by outcome during RESP
    always_comb begin
        loads_d  = loads_q;
        stores_d = stores_q;
        errs_d   = errs_q;
        if (state_q == RESP) begin
            if (err_q) begin
                errs_d = errs_q + 32'd1;
            end else if (req_q.we) begin
                stores_d = stores_q + 32'd1;
            end else begin
                loads_d = loads_q + 32'd1;
            end
        end
    end

    // Statistics counters
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else begin
            loads_q  <= loads_d;
            stores_q <= stores_d;
            errs_q   <= errs_d;
        end
    end

    assign stat_loads  = loads_q;
    assign stat_stores = stores_q;
    assign stat_errs   = errs_q;
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_errs   = '0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random transactions against a
// byte-addressable reference memory; a per-cycle compare process checks
// handshake, memory strobes and responses against the model's expectations.
module tb_load_store_unit;

    localparam int unsigned MEM_ADDR_W = 10;
    localparam int unsigned DEPTH      = 1 << MEM_ADDR_W;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [31:0]           req_addr;
    logic [31:0]           req_wdata;
    logic                  resp_valid;
    logic [31:0]           resp_rdata;
    logic                  resp_err;
    logic                  mem_wr_sel;
    logic [MEM_ADDR_W-1:0] mem_addr;
    logic [31:0]           mem_wr_data;
    logic [31:0]           mem_rd_data;
    logic [31:0]           stat_loads;
    logic [31:0]           stat_stores;
    logic [31:0]           stat_errs;

    load_store_unit #(.MEM_ADDR_W(MEM_ADDR_W), .XLEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_wr_sel   (mem_wr_sel),
        .mem_addr     (mem_addr),
        .mem_wr_data  (mem_wr_data),
        .mem_rd_data  (mem_rd_data),
        .stat_loads   (stat_loads),
        .stat_stores  (stat_stores),
        .stat_errs    (stat_errs)
    );

    always #5 clk = ~clk;

    // data_mem stand-in: combinational read, posedge write
    logic [31:0] dmem [DEPTH];
    assign mem_rd_data = dmem[mem_addr];
    always @(posedge clk) begin
        if (mem_wr_sel) dmem[mem_addr] <= mem_wr_data;
    end

    // Reference byte memory and expectation state
    logic [7:0]  ref_mem [4*DEPTH];
    int          errors = 0;
    int          checks = 0;
    bit          chk_en = 1'b0;
    bit          exp_active = 1'b0;
    int          exp_n = 0;
    int          exp_lat = 0;
    bit          exp_wr = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_rdata = '0;
    logic [31:0] exp_wdata = '0;
    logic [MEM_ADDR_W-1:0] exp_widx = '0;
    logic [31:0] last_rdata = '0;
    bit          last_err = 1'b0;
    int          last_lat = 0;
    logic [MEM_ADDR_W-1:0] last_wr_addr = '0;
    int          wr_pulses = 0;
    int          n_ld = 0;
    int          n_st = 0;
    int          n_er = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the transaction-level expectation
    always @(negedge clk) begin
        if (chk_en) begin
            bit rv_e;
            bit ws_e;
            bit acc_e;
            if (exp_active) exp_n++;
            rv_e  = exp_active && (exp_n == exp_lat);
            ws_e  = exp_active && exp_wr && (exp_n == exp_lat - 1);
            acc_e = exp_active && !exp_err && (exp_n < exp_lat);
            chk("req_ready", 32'(req_ready), 32'(!exp_active));
            chk("resp_valid", 32'(resp_valid), 32'(rv_e));
            chk("mem_wr_sel", 32'(mem_wr_sel), 32'(ws_e));
            if (acc_e) chk("mem_addr", 32'(mem_addr), 32'(exp_widx));
            if (ws_e) chk("mem_wr_data", mem_wr_data, exp_wdata);
            if (resp_valid) last_lat = exp_n;
            if (rv_e) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_err", 32'(resp_err), 32'(exp_err));
                last_rdata = resp_rdata;
                last_err   = resp_err;
                exp_active = 1'b0;
            end
        end
        if (mem_wr_sel) begin
            wr_pulses++;
            last_wr_addr = mem_addr;
        end
    end

    // Issue one request; called just after a posedge with the unit idle
    task automatic do_req(input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata);
        logic [31:0] val;
        int          nb;
        int          base;
        bit          err;
        err = (size == 2'd3) || (size == 2'd1 && addr[0]) ||
              (size == 2'd2 && addr[1:0] != 2'd0) || (addr >= 32'(4 * DEPTH));
        nb  = 1 << size;
        val = '0;
        if (!err) begin
            for (int b = 0; b < nb; b++) val |= 32'(ref_mem[int'(addr) + b]) << (8 * b);
            if (!we && !uns && nb < 4 && val[8*nb-1]) val |= 32'hFFFF_FFFF << (8 * nb);
            if (we) for (int b = 0; b < nb; b++) ref_mem[int'(addr) + b] = wdata[8*b +: 8];
            base      = int'(addr) & ~3;
            exp_wdata = {ref_mem[base+3], ref_mem[base+2], ref_mem[base+1], ref_mem[base]};
        end
        exp_rdata = (we || err) ? 32'd0 : val;
        exp_err   = err;
        exp_wr    = we && !err;
        exp_widx  = MEM_ADDR_W'(addr >> 2);
        exp_lat   = err ? 1 : ((!we || size == 2'd2) ? 2 : 3);
        if (err) n_er++;
        else if (we) n_st++;
        else n_ld++;
        last_rdata = 32'h5A5A_5A5A;
        #1;
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        exp_n      = 0;
        exp_active = 1'b1;
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        for (int i = 0; i < 8 && exp_active; i++) @(posedge clk);
        if (exp_active) begin
            errors++;
            checks++;
            $display("FAIL resp_timeout: no response for addr 0x%08h", addr);
            exp_active = 1'b0;
        end
    endtask

    task automatic do_lit(input string name, input bit we, input logic [1:0] size, input bit uns,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] lit_rdata, input bit lit_err);
        do_req(we, size, uns, addr, wdata);
        chk({name, "_rdata"}, last_rdata, lit_rdata);
        chk({name, "_err"}, 32'(last_err), 32'(lit_err));
    endtask

    task automatic pulse_reset();
        chk_en = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        n_ld = 0;
        n_st = 0;
        n_er = 0;
        chk_en = 1'b1;
    endtask

    initial begin
        int p0;
        int bad;
        logic [1:0]  sz;
        logic [31:0] ad;
        for (int w = 0; w < int'(DEPTH); w++) dmem[w] = '0;
        for (int b = 0; b < int'(4 * DEPTH); b++) ref_mem[b] = '0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = '0;
        req_wdata = '0;

        // Reset values
        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_mem_wr_sel", 32'(mem_wr_sel), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wr_data", mem_wr_data, 32'd0);
        chk("rst_stat_loads", stat_loads, 32'd0);
        chk("rst_stat_stores", stat_stores, 32'd0);
        chk("rst_stat_errs", stat_errs, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        chk_en = 1'b1;

        // Word store then load
        p0 = wr_pulses;
        do_lit("sw10", 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0);
        chk("sw10_pulses", 32'(wr_pulses - p0), 32'd1);
        chk("sw10_wr_addr", 32'(last_wr_addr), 32'd4);
        do_lit("lw10", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0);
        chk("lw10_latency", 32'(last_lat), 32'd2);

        // Byte store via read-modify-write
        do_lit("sb11", 1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00AA, 32'h0, 1'b0);
        chk("sb11_latency", 32'(last_lat), 32'd3);
        do_lit("lw10b", 1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 32'hDEAD_AAEF, 1'b0);
        do_lit("lb11", 1'b0, 2'd0, 1'b0, 32'h11, 32'h0, 32'hFFFF_FFAA, 1'b0);
        do_lit("lbu11", 1'b0, 2'd0, 1'b1, 32'h11, 32'h0, 32'h0000_00AA, 1'b0);

        // Half store and half loads
        do_lit("sh12", 1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234, 32'h0, 1'b0);
        do_lit("lh12", 1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 32'h0000_1234, 1'b0);
        do_lit("lhu10", 1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 32'h0000_AAEF, 1'b0);
        do_lit("lh10", 1'b0, 2'd1, 1'b0, 32'h10, 32'h0, 32'hFFFF_AAEF, 1'b0);

        // Error cases: no write, memory unchanged
        p0 = wr_pulses;
        do_lit("lh13", 1'b0, 2'd1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1);
        do_lit("sw16", 1'b1, 2'd2, 1'b0, 32'h16, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_lit("size3", 1'b0, 2'd3, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1);
        do_lit("lw_oor", 1'b0, 2'd2, 1'b0, 32'(4 * DEPTH), 32'h0, 32'h0, 1'b1);
        chk("err_pulses", 32'(wr_pulses - p0), 32'd0);
        chk("err_mem4", dmem[4], 32'h1234_AAEF);

        // Reset during the WRITE cycle of SB 0x20
        chk_en = 1'b0;
        p0 = wr_pulses;
        #1;
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'h0000_0055;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_wr_sel", 32'(mem_wr_sel), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        end
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        chk("abort_mem_wr_data", mem_wr_data, 32'd0);
        chk("abort_mem_addr", 32'(mem_addr), 32'd0);
        chk("abort_pulses", 32'(wr_pulses - p0), 32'd0);
        @(posedge clk);
        n_ld = 0; n_st = 0; n_er = 0;
        chk_en = 1'b1;
        do_lit("lw20", 1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0);

        // Statistics: 3 loads, 2 stores, 1 misaligned
        pulse_reset();
        do_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        do_req(1'b1, 2'd0, 1'b0, 32'h30, 32'h77);
        do_req(1'b0, 2'd0, 1'b1, 32'h30, 32'h0);
        do_req(1'b0, 2'd2, 1'b0, 32'h31, 32'h0);
        do_req(1'b1, 2'd2, 1'b0, 32'h34, 32'hCAFE_F00D);
        do_req(1'b0, 2'd1, 1'b0, 32'h36, 32'h0);
        @(negedge clk);
`ifdef LSU_STATS_EN
        chk("stat_loads_3", stat_loads, 32'd3);
        chk("stat_stores_2", stat_stores, 32'd2);
        chk("stat_errs_1", stat_errs, 32'd1);
`else
        chk("stat_loads_off", stat_loads, 32'd0);
        chk("stat_stores_off", stat_stores, 32'd0);
        chk("stat_errs_off", stat_errs, 32'd0);
`endif
        @(posedge clk);

        // Random traffic
        for (int t = 0; t < 1000; t++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r == 0) ad = $urandom;
            else if (r == 1) ad = 32'(4 * DEPTH) - 32'($urandom_range(1, 8));
            else ad = 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 0) ad = ad & ~(32'(1 << sz) - 32'd1);
            do_req(1'($urandom), sz, 1'($urandom), ad, $urandom);
        end
        @(negedge clk);
`ifdef LSU_STATS_EN
        chk("stat_loads_end", stat_loads, 32'(n_ld));
        chk("stat_stores_end", stat_stores, 32'(n_st));
        chk("stat_errs_end", stat_errs, 32'(n_er));
`else
        chk("stat_loads_end", stat_loads, 32'd0);
        chk("stat_stores_end", stat_stores, 32'd0);
        chk("stat_errs_end", stat_errs, 32'd0);
`endif

        bad = 0;
        for (int w = 0; w < int'(DEPTH); w++) begin
            if (dmem[w] !== {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]}) bad++;
        end
        chk("mem_image_bad_words", 32'(bad), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
